// File: rtl/dct4_pkg.sv
// dct4_pkg: shared types, the fixed Q1.7 4x4 DCT coefficient matrix and the
// per-pass round-half-up / saturate helper used by the engine and its MAC.
// No ports; imported by dct4_mac and dct4_engine.
package dct4_pkg;

  typedef enum logic {
    DCT_FWD = 1'b0,
    DCT_INV = 1'b1
  } dct_mode_e;

  typedef enum logic [1:0] {
    LOAD,
    PASS1,
    PASS2,
    DRAIN
  } dct_state_e;

  localparam int COEF_W = 8;
  // Wide enough for 4 products of a 10-bit operand and an 8-bit coefficient.
  localparam int SUM_W  = 32;

  localparam logic signed [COEF_W-1:0] DCT4_C [4][4] = '{
    '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{ 8'sd83,  8'sd34, -8'sd34, -8'sd83},
    '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{ 8'sd34, -8'sd83,  8'sd83, -8'sd34}
  };

  // Add half an LSB, arithmetic shift by frac, clamp to a signed w-bit range.
  // Every operand is kept signed so >>> stays arithmetic.
  function automatic logic signed [SUM_W-1:0] round_sat(
    input logic signed [SUM_W-1:0] sum,
    input int                      frac,
    input int                      w
  );
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    one = 1;
    rnd = (sum + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (rnd > hi)      return hi;
    else if (rnd < lo) return lo;
    else               return rnd;
  endfunction

endpackage

// File: rtl/dct4_mac.sv
// dct4_mac: combinational 4-tap signed dot product followed by round/saturate.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: a0..a3 signed operands, c0..c3 signed Q1.7 coefficients,
//   sel_b selects the clamp width (0 = W_A, 1 = W_B), res is the clamped result.
module dct4_mac
  import dct4_pkg::*;
#(
  parameter int OP_W  = 10,
  parameter int RES_W = 10,
  parameter int FRAC  = 7,
  parameter int W_A   = 10,
  parameter int W_B   = 10
) (
  input  logic signed [OP_W-1:0]   a0,
  input  logic signed [OP_W-1:0]   a1,
  input  logic signed [OP_W-1:0]   a2,
  input  logic signed [OP_W-1:0]   a3,
  input  logic signed [COEF_W-1:0] c0,
  input  logic signed [COEF_W-1:0] c1,
  input  logic signed [COEF_W-1:0] c2,
  input  logic signed [COEF_W-1:0] c3,
  input  logic                     sel_b,
  output logic signed [RES_W-1:0]  res
);

  logic signed [SUM_W-1:0] p0, p1, p2, p3, sum;

  always_comb begin
    p0  = SUM_W'(a0) * SUM_W'(c0);
    p1  = SUM_W'(a1) * SUM_W'(c1);
    p2  = SUM_W'(a2) * SUM_W'(c2);
    p3  = SUM_W'(a3) * SUM_W'(c3);
    sum = p0 + p1 + p2 + p3;
    // Clamped value always fits RES_W, so the truncating cast is lossless.
    res = RES_W'(round_sat(sum, FRAC, sel_b ? W_B : W_A));
  end

endmodule

// File: rtl/dct4_engine.sv
// dct4_engine: 4x4 two-pass integer DCT, forward or inverse per block.
// Latency: last input beat at edge t -> first output valid after edge t+32.
// Backpressure: in_ready high only in LOAD; out_ready low stalls DRAIN, data held.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_mode
//   input stream (mode sampled on beat 0); out_valid/out_ready/out_data/out_last
//   output stream, row-major, out_last on beat 15.
module dct4_engine
  import dct4_pkg::*;
#(
  parameter int DW_IN  = 8,
  parameter int DW_MID = 10,
  parameter int DW_OUT = 10,
  parameter int FRAC   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_OUT-1:0] out_data,
  output logic              out_last
);

  localparam int OP_W  = (DW_IN > DW_MID) ? DW_IN : DW_MID;
  localparam int RES_W = (DW_MID > DW_OUT) ? DW_MID : DW_OUT;

  dct_state_e state, state_nxt;
  dct_mode_e  mode;
  logic [3:0] cnt;

  // Matrix storage needs no reset: every entry is written before it is read.
  logic signed [DW_IN-1:0]  x_mem [16];
  logic signed [DW_MID-1:0] t_mem [16];
  logic signed [DW_OUT-1:0] r_mem [16];

  logic [1:0] row_i, col_j, c_row;
  logic       load_beat, drain_beat;

  logic signed [OP_W-1:0]   op_a [4];
  logic signed [COEF_W-1:0] op_c [4];
  logic signed [RES_W-1:0]  mac_res;

  assign row_i      = cnt[3:2];
  assign col_j      = cnt[1:0];
  assign load_beat  = (state == LOAD) && in_valid;
  assign drain_beat = (state == DRAIN) && out_ready;

  // Operand select for the shared MAC.
  // Pass 1 walks column j of X; pass 2 walks row i of T.
  // Forward reads coefficient row c_row, inverse reads coefficient column c_row.
  always_comb begin
    c_row = (state == PASS2) ? col_j : row_i;
    for (int k = 0; k < 4; k++) begin
      if (state == PASS2) op_a[k] = OP_W'(t_mem[{row_i, 2'(k)}]);
      else                op_a[k] = OP_W'(x_mem[{2'(k), col_j}]);
      op_c[k] = (mode == DCT_INV) ? DCT4_C[2'(k)][c_row] : DCT4_C[c_row][2'(k)];
    end
  end

  dct4_mac #(
    .OP_W (OP_W),
    .RES_W(RES_W),
    .FRAC (FRAC),
    .W_A  (DW_MID),
    .W_B  (DW_OUT)
  ) u_mac (
    .a0   (op_a[0]),
    .a1   (op_a[1]),
    .a2   (op_a[2]),
    .a3   (op_a[3]),
    .c0   (op_c[0]),
    .c1   (op_c[1]),
    .c2   (op_c[2]),
    .c3   (op_c[3]),
    .sel_b(state == PASS2),
    .res  (mac_res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic; every phase ends when cnt wraps past 15.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && cnt == 4'd15)   state_nxt = PASS1;
      PASS1:   if (cnt == 4'd15)               state_nxt = PASS2;
      PASS2:   if (cnt == 4'd15)               state_nxt = DRAIN;
      DRAIN:   if (out_ready && cnt == 4'd15)  state_nxt = LOAD;
      default:                                 state_nxt = LOAD;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    out_data  = '0;
    out_last  = 1'b0;
    if (state == DRAIN) begin
      out_data = r_mem[cnt];
      out_last = (cnt == 4'd15);
    end
  end

  // Shared element counter and latched block mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      mode <= DCT_FWD;
    end else begin
      if (load_beat || state == PASS1 || state == PASS2 || drain_beat)
        cnt <= cnt + 4'd1;
      if (load_beat && cnt == 4'd0)
        mode <= dct_mode_e'(in_mode);
    end
  end

  // Matrix writes.
  always_ff @(posedge clk) begin
    if (load_beat)       x_mem[cnt] <= in_data;
    if (state == PASS1)  t_mem[cnt] <= DW_MID'(mac_res);
    if (state == PASS2)  r_mem[cnt] <= DW_OUT'(mac_res);
  end

endmodule

// File: tb/tb_dct4_engine.sv
// tb_dct4_engine: randomized scoreboard bench for dct4_engine.
// Two instances share the input stream: DW_OUT=10 and DW_OUT=8 (saturation).
// Expected blocks come from a plain matrix-arithmetic reference model.
module tb_dct4_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_last;
  logic [9:0] out_data;
  logic       in_ready8, out_valid8, out_last8;
  logic [7:0] out_data8;

  always #5 clk = ~clk;

  dct4_engine #(.DW_IN(8), .DW_MID(10), .DW_OUT(10), .FRAC(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  dct4_engine #(.DW_IN(8), .DW_MID(10), .DW_OUT(8), .FRAC(7)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid8),
    .out_ready(out_ready), .out_data(out_data8), .out_last(out_last8)
  );

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t q10[$];
  exp_t q8[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  int   xin[16];
  int   cm[4][4] = '{'{64, 64, 64, 64}, '{83, 34, -34, -83},
                     '{64, -64, -64, 64}, '{34, -83, 83, -34}};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rsat(input int s, input int w);
    int r;
    r = (s + 64) >>> 7;
    if (r > (1 << (w - 1)) - 1) r = (1 << (w - 1)) - 1;
    if (r < -(1 << (w - 1)))    r = -(1 << (w - 1));
    return r;
  endfunction

  // Reference: Y = C*X*C' (forward) or X = C'*Y*C (inverse), rounded per pass.
  function automatic void model(input bit inv);
    int   t[16];
    int   s;
    exp_t e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += (inv ? cm[k][i] : cm[i][k]) * xin[k*4 + j];
        t[i*4 + j] = rsat(s, 10);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += t[i*4 + k] * (inv ? cm[k][j] : cm[j][k]);
        e.last = (i == 3 && j == 3);
        e.data = rsat(s, 10);
        q10.push_back(e);
        e.data = rsat(s, 8);
        q8.push_back(e);
      end
  endfunction

  // Monitor: compare every presented output against the queue head.
  bit stall10 = 0, stall8 = 0;
  int pd10 = 0, pd8 = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q10.size() == 0) check("spurious_out10", 1, 0);
        else begin
          check("out_data10", $signed(out_data), q10[0].data);
          check("out_last10", int'(out_last), int'(q10[0].last));
        end
        if (stall10) check("hold10", $signed(out_data), pd10);
        if (out_ready && q10.size() > 0) void'(q10.pop_front());
        stall10 = !out_ready;
        pd10 = $signed(out_data);
      end else stall10 = 0;
      if (rst_n && out_valid8) begin
        if (q8.size() == 0) check("spurious_out8", 1, 0);
        else begin
          check("out_data8", $signed(out_data8), q8[0].data);
          check("out_last8", int'(out_last8), int'(q8[0].last));
        end
        if (stall8) check("hold8", $signed(out_data8), pd8);
        if (out_ready && q8.size() > 0) void'(q8.pop_front());
        stall8 = !out_ready;
        pd8 = $signed(out_data8);
      end else stall8 = 0;
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  // Push the expected block and stream its 16 input beats.
  task automatic feed(input bit inv, input bit gaps);
    int n = 0;
    while (!in_ready && n < 2000) begin tick(); n++; end
    check("in_ready_wait", int'(in_ready), 1);
    model(inv);
    for (int k = 0; k < 16; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_mode  = 1'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = 8'(xin[k]);
      in_mode  = (k == 0) ? inv : 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    in_mode  = 1'($urandom);
  endtask

  // Full block: feed, then measure the latency to the first output.
  task automatic send_block(input bit inv, input bit gaps, input bit pulses);
    int n = 0;
    feed(inv, gaps);
    check("in_ready_fall", int'(in_ready), 0);
    check("in_ready8_fall", int'(in_ready8), 0);
    while (!out_valid && n < 100) begin
      if (pulses && n < 10) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("first_out_latency", n, 32);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q10.size() != 0 || q8.size() != 0) && n < 3000) begin tick(); n++; end
    check("drain_q10_empty", q10.size(), 0);
    check("drain_q8_empty", q8.size(), 0);
    tick();
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Forward, constant 10 -> DC 40.
    for (int k = 0; k < 16; k++) xin[k] = 10;
    send_block(1'b0, 1'b0, 1'b0);
    wait_drain();

    // Inverse of a lone DC 127 -> flat 32.
    for (int k = 0; k < 16; k++) xin[k] = 0;
    xin[0] = 127;
    send_block(1'b1, 1'b0, 1'b0);
    wait_drain();

    // Forward, constant 127 -> 508 at 10 bits, saturates to 127 at 8 bits.
    for (int k = 0; k < 16; k++) xin[k] = 127;
    send_block(1'b0, 1'b0, 1'b0);
    wait_drain();

    // Input gaps, pulses during PASS1, and a 5-cycle stall mid-DRAIN.
    for (int k = 0; k < 16; k++) xin[k] = $urandom_range(0, 255) - 128;
    send_block(1'b0, 1'b1, 1'b1);
    repeat (6) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back random blocks, random mode, gaps and backpressure.
    ready_mode = 1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 16; k++) xin[k] = $urandom_range(0, 255) - 128;
      send_block(1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_drain();
    ready_mode = 0;
    out_ready = 1'b1;
    tick();

    // Reset during PASS2, then a fresh all-10 forward block.
    for (int k = 0; k < 16; k++) xin[k] = $urandom_range(0, 255) - 128;
    feed(1'b1, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    q10.delete();
    q8.delete();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) xin[k] = 10;
    send_block(1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
